// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Helpers operate on a wide word; callers zero-extend and truncate to their pointer width.
package async_fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int unsigned ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits contribute nothing, so this is exact for any narrower width.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = '0;
        for (int i = 0; i < int'(MAX_PTR_W); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_ptr_sync.sv
// Multi-bit flop chain carrying a gray pointer into the local clock domain.
module ptr_sync #(
    parameter int unsigned W      = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer and flag controller of the asynchronous FIFO, read clock domain only.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_gray_async,
    output logic [ADDR_W:0]   rd_gray,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_fire,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam int unsigned PTR_W = ptr_w(ADDR_W);

    logic [PTR_W-1:0] wr_gray_sync;
    logic [PTR_W-1:0] wr_bin_sync;
    logic [PTR_W-1:0] rd_bin_q,  rd_bin_d;
    logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0] count_q,   count_d;
    logic             empty_q,   empty_d;
    logic             aempty_q,  aempty_d;
    logic             uflow_q,   uflow_d;

    ptr_sync #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk (clk),
        .rst (rst),
        .d_i (wr_gray_async),
        .q_o (wr_gray_sync)
    );

    assign wr_bin_sync = PTR_W'(gray2bin(MAX_PTR_W'(wr_gray_sync)));
    assign rd_fire     = rd_en & ~empty_q;

    // Flags look at the post-read pointer so they line up with the new rd_addr.
    always_comb begin
        rd_bin_d  = rd_bin_q + PTR_W'(rd_fire);
        rd_gray_d = PTR_W'(bin2gray(MAX_PTR_W'(rd_bin_d)));
        count_d   = wr_bin_sync - rd_bin_d;
        empty_d   = (rd_gray_d == wr_gray_sync);
        aempty_d  = (count_d <= PTR_W'(AEMPTY_THRESH));
        uflow_d   = rd_en & empty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            uflow_q   <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            uflow_q   <= uflow_d;
        end
    end

    assign rd_gray      = rd_gray_q;
    assign rd_addr      = rd_bin_q[ADDR_W-1:0];
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign rd_count     = count_q;
    assign underflow    = uflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Scenario bench for async_fifo_rd_ctrl against an occupancy-level reference model.
module tb_async_fifo_rd_ctrl;

    logic       clk;
    logic       rst;
    logic       rd_en;
    logic [4:0] wr_gray_async;
    logic [4:0] rd_gray;
    logic [3:0] rd_addr;
    logic       rd_fire;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_count;
    logic       underflow;

    int vectors;
    int miscompares;

    // Reference model: read count, occupancy, and a two-deep history of write pointers seen
    int m_rd;
    int m_count;
    bit m_empty;
    bit m_uf;
    int wq[$];
    bit cur_rd;
    int cur_w;

    async_fifo_rd_ctrl #(
        .ADDR_W        (4),
        .SYNC_STAGES   (2),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .wr_gray_async (wr_gray_async),
        .rd_gray       (rd_gray),
        .rd_addr       (rd_addr),
        .rd_fire       (rd_fire),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_count      (rd_count),
        .underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    task automatic model_reset();
        m_rd = 0; m_count = 0; m_empty = 1'b1; m_uf = 1'b0;
        wq.delete(); wq.push_back(0); wq.push_back(0);
    endtask

    task automatic set_in(input bit rd, input int w);
        cur_rd = rd; cur_w = w;
        rd_en = rd; wr_gray_async = to_gray(w);
    endtask

    // One clock: the write pointer seen now is the one presented two edges earlier.
    task automatic tick();
        bit fire;
        @(posedge clk);
        fire    = cur_rd && !m_empty;
        m_uf    = cur_rd && m_empty;
        m_rd    = (m_rd + int'(fire)) % 32;
        m_count = (wq[0] - m_rd + 32) % 32;
        m_empty = (m_count == 0);
        wq.push_back(cur_w);
        void'(wq.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; set_in(0, 0); model_reset();
        #2 rst = 1'b0;
    endtask

    task automatic go_to(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            set_in(!m_empty, target);
            tick();
            done = (m_rd == target) && m_empty && (wq[0] == target);
        end
        set_in(0, target);
        vectors++;
        if (!done) begin miscompares++; $display("FAIL go_to timeout target=%0d rd=%0d", target, m_rd); end
    endtask

    task automatic test_reset();
        set_in(0, 7);
        repeat (3) tick();
        set_in(1, 7);
        repeat (7) tick();
        set_in(0, 7);
        vectors++; if (rd_addr !== 4'd7) begin miscompares++; $display("FAIL pre_reset_addr got %0d want 7", rd_addr); end
        rst = 1'b1; set_in(0, 0);
        #1;
        vectors++; if (rd_gray !== 5'd0) begin miscompares++; $display("FAIL rst_gray got %b want 00000", rd_gray); end
        vectors++; if (rd_addr !== 4'd0) begin miscompares++; $display("FAIL rst_addr got %0d want 0", rd_addr); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", empty); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_aempty got %b want 1", almost_empty); end
        vectors++; if (rd_count !== 5'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", rd_count); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL rst_uflow got %b want 0", underflow); end
        model_reset();
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        set_in(0, 3);
        tick(); tick();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fill_early_empty got %b want 1", empty); end
        tick();
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty got %b want 0", empty); end
        vectors++; if (rd_count !== 5'd3) begin miscompares++; $display("FAIL fill_count got %0d want 3", rd_count); end
        vectors++; if (almost_empty !== 1'b0) begin miscompares++; $display("FAIL fill_aempty got %b want 0", almost_empty); end
        set_in(1, 3); tick();
        vectors++; if (rd_count !== 5'd2) begin miscompares++; $display("FAIL rd1_count got %0d want 2", rd_count); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL rd1_aempty got %b want 1", almost_empty); end
        vectors++; if (rd_addr !== 4'd1 || rd_gray !== 5'b00001) begin miscompares++; $display("FAIL rd1_ptr got %0d/%b want 1/00001", rd_addr, rd_gray); end
        tick();
        vectors++; if (rd_addr !== 4'd2 || rd_gray !== 5'b00011) begin miscompares++; $display("FAIL rd2_ptr got %0d/%b want 2/00011", rd_addr, rd_gray); end
        tick();
        vectors++; if (rd_addr !== 4'd3 || rd_gray !== 5'b00010) begin miscompares++; $display("FAIL rd3_ptr got %0d/%b want 3/00010", rd_addr, rd_gray); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rd3_empty got %b want 1", empty); end
        #1;
        vectors++; if (rd_fire !== 1'b0) begin miscompares++; $display("FAIL uf_fire got %b want 0", rd_fire); end
        tick();
        vectors++; if (underflow !== 1'b1 || rd_addr !== 4'd3) begin miscompares++; $display("FAIL uf_pulse got %b/%0d want 1/3", underflow, rd_addr); end
        set_in(0, 3); tick();
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear got %b want 0", underflow); end
    endtask

    task automatic test_wrap();
        int exp_addr [4];
        exp_addr = '{14, 15, 0, 1};
        go_to(18);
        go_to(30);
        vectors++; if (rd_addr !== 4'd14 || empty !== 1'b1) begin miscompares++; $display("FAIL wrap_pre got %0d/%b want 14/1", rd_addr, empty); end
        set_in(0, 2);
        repeat (3) tick();
        vectors++; if (rd_count !== 5'd4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", rd_count); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd_addr !== 4'(exp_addr[k])) begin miscompares++; $display("FAIL wrap_addr[%0d] got %0d want %0d", k, rd_addr, exp_addr[k]); end
            set_in(1, 2); tick();
        end
        set_in(0, 2);
        vectors++; if (empty !== 1'b1 || rd_count !== 5'd0) begin miscompares++; $display("FAIL wrap_end got %b/%0d want 1/0", empty, rd_count); end
    endtask

    task automatic test_full();
        do_reset();
        set_in(0, 16);
        vectors++; if (wr_gray_async !== 5'b11000) begin miscompares++; $display("FAIL full_gray_in got %b want 11000", wr_gray_async); end
        repeat (3) tick();
        vectors++; if (rd_count !== 5'd16) begin miscompares++; $display("FAIL full_count got %0d want 16", rd_count); end
        vectors++; if (empty !== 1'b0 || almost_empty !== 1'b0) begin miscompares++; $display("FAIL full_flags got %b/%b want 0/0", empty, almost_empty); end
    endtask

    task automatic test_inflight();
        do_reset();
        set_in(0, 1);
        repeat (3) tick();
        vectors++; if (rd_count !== 5'd1 || empty !== 1'b0) begin miscompares++; $display("FAIL infl_pre got %0d/%b want 1/0", rd_count, empty); end
        set_in(1, 2);
        #1;
        vectors++; if (rd_fire !== 1'b1) begin miscompares++; $display("FAIL infl_fire got %b want 1", rd_fire); end
        tick();
        set_in(0, 2);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (empty !== 1'b1 || underflow !== 1'b0 || rd_fire !== 1'b0) begin
                miscompares++; $display("FAIL infl_hold[%0d] got e=%b u=%b f=%b want 1/0/0", k, empty, underflow, rd_fire);
            end
            tick();
        end
        vectors++; if (empty !== 1'b0 || rd_count !== 5'd1) begin miscompares++; $display("FAIL infl_end got %b/%0d want 0/1", empty, rd_count); end
    endtask

    task automatic test_random();
        int w;
        bit rd;
        logic [4:0] prev_g;
        do_reset();
        w = 0;
        prev_g = 5'd0;
        for (int i = 0; i < 500; i++) begin
            rd = ($urandom % 10) < 6;
            if ((w - m_rd + 32) % 32 < 16 && ($urandom % 2) == 1) w = (w + 1) % 32;
            set_in(rd, w);
            #1;
            vectors++; if (rd_fire !== (rd && !m_empty)) begin miscompares++; $display("FAIL rnd_fire cyc %0d got %b want %b", i, rd_fire, rd && !m_empty); end
            tick();
            vectors++; if (rd_gray !== to_gray(m_rd)) begin miscompares++; $display("FAIL rnd_gray cyc %0d got %b want %b", i, rd_gray, to_gray(m_rd)); end
            vectors++; if (rd_addr !== 4'(m_rd % 16)) begin miscompares++; $display("FAIL rnd_addr cyc %0d got %0d want %0d", i, rd_addr, m_rd % 16); end
            vectors++; if (rd_count !== 5'(m_count)) begin miscompares++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, rd_count, m_count); end
            vectors++; if (empty !== m_empty) begin miscompares++; $display("FAIL rnd_empty cyc %0d got %b want %b", i, empty, m_empty); end
            vectors++; if (almost_empty !== (m_count <= 2)) begin miscompares++; $display("FAIL rnd_aempty cyc %0d got %b want %b", i, almost_empty, m_count <= 2); end
            vectors++; if (underflow !== m_uf) begin miscompares++; $display("FAIL rnd_uflow cyc %0d got %b want %b", i, underflow, m_uf); end
            vectors++; if ($countones(rd_gray ^ prev_g) > 1) begin miscompares++; $display("FAIL rnd_hamming cyc %0d got %b prev %b want <=1 bit change", i, rd_gray, prev_g); end
            vectors++; if (rd_count > 5'd16) begin miscompares++; $display("FAIL rnd_count_max cyc %0d got %0d want <=16", i, rd_count); end
            prev_g = rd_gray;
        end
        set_in(0, w);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        set_in(0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full();
        test_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
